// File: rtl/counter_share_arbiter_if.sv
// Bundle between the counter-share arbiter, its two timing clients and the shared
// 4-bit up-counter. The slave side is the arbiter.
interface counter_share_arbiter_if #(
   parameter int CNT_W = 4
) ();
   logic [1:0]       req;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;
   logic             cnt_ld;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_rc;

   modport master (
      output req, len0, len1, cnt_q, cnt_rc,
      input  gnt, done, busy, cnt_ld, cnt_en, cnt_d
   );

   modport slave (
      input  req, len0, len1, cnt_q, cnt_rc,
      output gnt, done, busy, cnt_ld, cnt_en, cnt_d
   );
endinterface

// File: rtl/counter_share_arbiter.sv
// Two-requester arbiter/sequencer for one shared up-counter: loads the complement of
// the granted interval length, counts to ripple carry, then pulses done.
module counter_share_arbiter #(
   parameter int CNT_W = 4,
   parameter bit RR_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   counter_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state_reg;
   logic             g_reg;
   logic             last_reg;
   logic [1:0]       gnt_reg;
   logic [1:0]       done_reg;
   logic             busy_reg;
   logic             cnt_ld_reg;
   logic [CNT_W-1:0] cnt_d_reg;

   logic [CNT_W-1:0] len_vec   [2];
   logic [CNT_W-1:0] start_vec [2];
   logic             arb_g;
   logic             req_g;

   assign len_vec[0] = bus.len0;
   assign len_vec[1] = bus.len1;

   // Start value is (2^CNT_W - len) mod 2^CNT_W, so len = 0 yields a full 16-tick run.
   for (genvar gi = 0; gi < 2; gi++) begin : g_start
      assign start_vec[gi] = -len_vec[gi];
   end

   always_comb begin
      arb_g = 1'b0;
      if (bus.req == 2'b10) begin
         arb_g = 1'b1;
      end else if (bus.req == 2'b11 && RR_EN) begin
         arb_g = ~last_reg;
      end
   end

   assign req_g = bus.req[g_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         g_reg      <= 1'b0;
         last_reg   <= 1'b1;
         gnt_reg    <= 2'b00;
         done_reg   <= 2'b00;
         busy_reg   <= 1'b0;
         cnt_ld_reg <= 1'b0;
         cnt_d_reg  <= '0;
      end else begin
         done_reg   <= 2'b00;
         cnt_ld_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  state_reg  <= LOAD;
                  g_reg      <= arb_g;
                  gnt_reg    <= arb_g ? 2'b10 : 2'b01;
                  busy_reg   <= 1'b1;
                  cnt_ld_reg <= 1'b1;
                  cnt_d_reg  <= start_vec[arb_g];
               end
            end
            LOAD, RUN: begin
               // A dropped request aborts silently and leaves the pointer alone.
               if (!req_g) begin
                  state_reg <= IDLE;
                  gnt_reg   <= 2'b00;
                  busy_reg  <= 1'b0;
               end else if (state_reg == LOAD) begin
                  state_reg <= RUN;
               end else if (bus.cnt_rc) begin
                  state_reg <= DONE;
                  done_reg  <= gnt_reg;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               gnt_reg   <= 2'b00;
               busy_reg  <= 1'b0;
               last_reg  <= g_reg;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.gnt    = gnt_reg;
   assign bus.done   = done_reg;
   assign bus.busy   = busy_reg;
   assign bus.cnt_ld = cnt_ld_reg;
   assign bus.cnt_d  = cnt_d_reg;
   // Enable is the one combinational output so the counter stops exactly on 4'hF.
   assign bus.cnt_en = (state_reg == RUN) && !bus.cnt_rc;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: a round-robin and a fixed-priority instance, each
// with its own counter, checked every cycle against an interval-timeline model.
module tb_counter_share_arbiter;
   localparam int NI = 2;   // instance 0: RR_EN = 1, instance 1: RR_EN = 0

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0] req_s  [NI];
   logic [3:0] len_s  [NI][2];
   logic [1:0] gnt_o  [NI];
   logic [1:0] done_o [NI];
   logic       busy_o [NI];
   logic       ld_o   [NI];
   logic       en_o   [NI];
   logic [3:0] cd_o   [NI];
   logic [3:0] q_o    [NI];

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      counter_share_arbiter_if #(.CNT_W(4)) bus ();
      logic [3:0] q_reg = 4'h0;

      counter_share_arbiter #(.CNT_W(4), .RR_EN(gi == 0)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      always @(posedge clk) begin
         if (bus.cnt_ld) q_reg <= bus.cnt_d;
         else if (bus.cnt_en) q_reg <= q_reg + 4'd1;
      end

      assign bus.cnt_q  = q_reg;
      assign bus.cnt_rc = (q_reg == 4'hF);
      assign bus.req    = req_s[gi];
      assign bus.len0   = len_s[gi][0];
      assign bus.len1   = len_s[gi][1];
      assign gnt_o[gi]  = bus.gnt;
      assign done_o[gi] = bus.done;
      assign busy_o[gi] = bus.busy;
      assign ld_o[gi]   = bus.cnt_ld;
      assign en_o[gi]   = bus.cnt_en;
      assign cd_o[gi]   = bus.cnt_d;
      assign q_o[gi]    = q_reg;
   end

   // Model: an active interval is tracked as a cycle index t since the grant edge:
   // t = 1 load, 2..L+1 counting, L+2 done pulse.
   int m_act [NI];
   int m_t   [NI];
   int m_g   [NI];
   int m_l   [NI];
   int m_ptr [NI];
   int cyc = 0;

   always @(posedge clk or posedge rst) begin
      int w;
      if (rst) begin
         for (int k = 0; k < NI; k++) begin
            m_act[k] = 0;
            m_ptr[k] = 1;
         end
      end else begin
         cyc = cyc + 1;
         for (int k = 0; k < NI; k++) begin
            if (m_act[k] == 0) begin
               if (req_s[k] != 2'b00) begin
                  if (req_s[k] == 2'b01) w = 0;
                  else if (req_s[k] == 2'b10) w = 1;
                  else w = (k == 0) ? 1 - m_ptr[k] : 0;
                  m_act[k] = 1;
                  m_t[k]   = 1;
                  m_g[k]   = w;
                  m_l[k]   = (len_s[k][w] == 4'd0) ? 16 : int'(len_s[k][w]);
               end
            end else if (m_t[k] <= m_l[k] + 1 && req_s[k][m_g[k]] == 1'b0) begin
               m_act[k] = 0;
            end else if (m_t[k] == m_l[k] + 2) begin
               m_act[k] = 0;
               m_ptr[k] = m_g[k];
            end else begin
               m_t[k] = m_t[k] + 1;
            end
         end
      end
   end

   int         n_chk  = 0;
   int         n_fail = 0;
   int         jobs      [NI][2];
   int         abort_at  [NI][2];
   int         e0        [NI][2];
   int         done_cnt  [NI][2];
   int         done_cyc  [NI][2];
   logic [3:0] ld_cd     [NI][2];
   int         grant_log [NI][$];
   bit         rand_mode = 1'b0;

   task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      logic [1:0] e_gnt;
      logic [1:0] e_done;
      int         gidx;
      for (int k = 0; k < NI; k++) begin
         e_gnt  = (m_act[k] != 0) ? (2'b01 << m_g[k]) : 2'b00;
         e_done = (m_act[k] != 0 && m_t[k] == m_l[k] + 2) ? e_gnt : 2'b00;
         chk("gnt", k, 8'(gnt_o[k]), 8'(e_gnt));
         chk("done", k, 8'(done_o[k]), 8'(e_done));
         chk("busy", k, 8'(busy_o[k]), 8'(m_act[k] != 0));
         chk("cnt_ld", k, 8'(ld_o[k]), 8'(m_act[k] != 0 && m_t[k] == 1));
         chk("cnt_en", k, 8'(en_o[k]), 8'(m_act[k] != 0 && m_t[k] >= 2 && m_t[k] <= m_l[k]));
         if (rst) chk("cnt_d_rst", k, 8'(cd_o[k]), 8'h00);
         else if (m_act[k] != 0 && m_t[k] == 1) chk("cnt_d", k, 8'(cd_o[k]), 8'((16 - m_l[k]) % 16));
         if (m_act[k] != 0 && m_t[k] >= 2 && m_t[k] <= m_l[k] + 1)
            chk("cnt_q", k, 8'(q_o[k]), 8'(16 - m_l[k] + m_t[k] - 2));
         if (ld_o[k] === 1'b1) begin
            gidx = (gnt_o[k][1] === 1'b1) ? 1 : 0;
            grant_log[k].push_back(gidx);
            ld_cd[k][gidx] = cd_o[k];
         end
         for (int i = 0; i < 2; i++) begin
            if (done_o[k][i] === 1'b1) begin
               done_cnt[k][i]++;
               done_cyc[k][i] = cyc - e0[k][i] + 1;
            end
         end
      end
   endtask

   // Requesters: raise when jobs remain, drop on done, optional directed or random abort.
   task automatic drive_agents();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (req_s[k][i]) begin
               if (done_o[k][i] === 1'b1) begin
                  req_s[k][i] = 1'b0;
                  if (jobs[k][i] > 0) jobs[k][i]--;
               end else if (abort_at[k][i] != 0 && cyc - e0[k][i] + 1 == abort_at[k][i]) begin
                  req_s[k][i]    = 1'b0;
                  abort_at[k][i] = 0;
                  if (jobs[k][i] > 0) jobs[k][i]--;
               end else if (rand_mode && $urandom_range(0, 59) == 0) begin
                  req_s[k][i] = 1'b0;
               end
            end else if (jobs[k][i] > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
               if (rand_mode) len_s[k][i] = 4'($urandom_range(0, 15));
               req_s[k][i] = 1'b1;
               e0[k][i]    = cyc + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      if (!rst) drive_agents();
   endtask

   function automatic bit quiet();
      for (int k = 0; k < NI; k++) begin
         if (m_act[k] != 0) return 1'b0;
         for (int i = 0; i < 2; i++)
            if (jobs[k][i] != 0 || req_s[k][i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run_until_quiet(input string nm, input int maxc);
      int n = 0;
      while (n < maxc && !quiet()) begin
         tick();
         n++;
      end
      n_chk++;
      if (!quiet()) begin
         n_fail++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle", nm, maxc);
      end
   endtask

   // pat bit j = requester expected for the j-th grant since base.
   task automatic chk_seq(input string nm, input int k, input int base, input int n, input logic [7:0] pat);
      chk({nm, "_len"}, k, 8'(grant_log[k].size() - base), 8'(n));
      for (int j = 0; j < n; j++)
         if (base + j < grant_log[k].size())
            chk(nm, k, 8'(grant_log[k][base + j]), 8'(pat[j]));
   endtask

   task automatic set_jobs(input int l0, input int j0, input int l1, input int j1);
      for (int k = 0; k < NI; k++) begin
         len_s[k][0] = 4'(l0);
         len_s[k][1] = 4'(l1);
         jobs[k][0]  = j0;
         jobs[k][1]  = j1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         req_s[k] = 2'b00;
         for (int i = 0; i < 2; i++) begin
            jobs[k][i]     = 0;
            abort_at[k][i] = 0;
         end
      end
      tick();
      tick();
      rst = 1'b0;
   endtask

   int base [NI];
   int dc0  [NI];
   int dc1  [NI];

   initial begin
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         req_s[k] = 2'b00;
         for (int i = 0; i < 2; i++) begin
            len_s[k][i] = 4'd0; jobs[k][i] = 0; abort_at[k][i] = 0;
            e0[k][i] = 0; done_cnt[k][i] = 0; done_cyc[k][i] = 0; ld_cd[k][i] = 4'h0;
         end
      end
      do_reset();

      // 1: single request, len0 = 3
      set_jobs(3, 1, 0, 0);
      run_until_quiet("t1", 60);
      for (int k = 0; k < NI; k++) begin
         chk("t1_cnt_d", k, 8'(ld_cd[k][0]), 8'h0D);
         chk("t1_done_cycle", k, 8'(done_cyc[k][0]), 8'd5);
         chk("t1_done_count", k, 8'(done_cnt[k][0]), 8'd1);
      end

      // 2: both from reset, len0 = 2, len1 = 5
      do_reset();
      set_jobs(2, 1, 5, 1);
      run_until_quiet("t2", 80);
      for (int k = 0; k < NI; k++) begin
         chk("t2_done0_cycle", k, 8'(done_cyc[k][0]), 8'd4);
         chk("t2_done1_cycle", k, 8'(done_cyc[k][1]), 8'd12);
         chk("t2_cnt_d1", k, 8'(ld_cd[k][1]), 8'h0B);
      end

      // 3: continuous re-requests
      for (int k = 0; k < NI; k++) base[k] = grant_log[k].size();
      set_jobs(1, 2, 2, 2);
      run_until_quiet("t3", 120);
      chk_seq("t3_rr_order", 0, base[0], 4, 8'b1010);
      chk_seq("t3_fixed_order", 1, base[1], 4, 8'b1100);

      // 4: len1 = 0 encodes a 16-cycle run
      set_jobs(0, 0, 0, 1);
      run_until_quiet("t4", 80);
      for (int k = 0; k < NI; k++) begin
         chk("t4_cnt_d", k, 8'(ld_cd[k][1]), 8'h00);
         chk("t4_done_cycle", k, 8'(done_cyc[k][1]), 8'd18);
      end

      // 5: requester 0 aborts in its second counting cycle, requester 1 pending
      for (int k = 0; k < NI; k++) begin
         base[k] = grant_log[k].size();
         dc0[k]  = done_cnt[k][0];
         dc1[k]  = done_cnt[k][1];
         abort_at[k][0] = 3;
      end
      set_jobs(6, 1, 2, 1);
      run_until_quiet("t5", 80);
      for (int k = 0; k < NI; k++) begin
         chk_seq("t5_order", k, base[k], 2, 8'b10);
         chk("t5_no_done0", k, 8'(done_cnt[k][0] - dc0[k]), 8'd0);
         chk("t5_done1", k, 8'(done_cnt[k][1] - dc1[k]), 8'd1);
      end

      // 6: asynchronous reset in the middle of a run
      set_jobs(8, 1, 0, 0);
      repeat (4) tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("t6_busy_before", k, 8'(busy_o[k]), 8'd1);
         chk("t6_en_before", k, 8'(en_o[k]), 8'd1);
      end
      #1;
      rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("t6_gnt_async", k, 8'(gnt_o[k]), 8'd0);
         chk("t6_en_async", k, 8'(en_o[k]), 8'd0);
         chk("t6_busy_async", k, 8'(busy_o[k]), 8'd0);
         chk("t6_ld_async", k, 8'(ld_o[k]), 8'd0);
      end
      do_reset();
      for (int k = 0; k < NI; k++) base[k] = grant_log[k].size();
      set_jobs(3, 1, 3, 1);
      run_until_quiet("t6", 60);
      for (int k = 0; k < NI; k++) chk_seq("t6_after_reset", k, base[k], 2, 8'b10);

      // Random traffic with random lengths, aborts and withdrawals
      rand_mode = 1'b1;
      set_jobs(0, 1000, 0, 1000);
      repeat (3000) tick();
      rand_mode = 1'b0;
      set_jobs(0, 0, 0, 0);
      run_until_quiet("random_drain", 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end
endmodule
